// File: rtl/uart_rx_fifo.sv
// UART receiver (8E1, 2-of-3 majority sampling) feeding a first-word-fall-through FIFO,
// with sticky parity, framing and overrun flags.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_rx,
    input  logic                               i_rd_en,
    input  logic                               i_clr_err,
    output logic [7:0]                         o_data_byte,
    output logic                               o_data_avail,
    output logic                               o_fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic                               o_parity_err,
    output logic                               o_frame_err,
    output logic                               o_overrun
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntFW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0] SmpA    = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] SmpB    = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] DecCnt  = CntW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic            rx_meta_q, rx_s, rx_prev_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [1:0]      samp_q;
    logic [7:0]      shift_q;
    logic            par_bad_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntFW-1:0] count_q;

    logic maj, decide, at_last, stop_done;
    logic push, pop, full, do_push;
    logic frame_evt, parity_evt, overrun_evt;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s      <= rx_meta_q;
            rx_prev_q <= rx_s;
        end
    end

    // Bit decision: the third vote is the live sample on the decision cycle.
    always_comb begin
        maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
        decide     = (state_q != StIdle) && (cnt_q == DecCnt);
        at_last    = (cnt_q == LastCnt);
        stop_done  = (state_q == StStop) && decide;
        push       = stop_done && maj && !par_bad_q;
        frame_evt  = stop_done && !maj;
        parity_evt = stop_done && maj && par_bad_q;
    end

    // Receive FSM: bit timing, sampling and shifting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            samp_q    <= 2'b11;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            if (state_q != StIdle) begin
                cnt_q <= at_last ? '0 : cnt_q + CntW'(1);
                if (cnt_q == SmpA) samp_q[0] <= rx_s;
                if (cnt_q == SmpB) samp_q[1] <= rx_s;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (rx_prev_q && !rx_s) state_q <= StStart;
                end
                StStart: begin
                    if (decide && maj) state_q <= StIdle;  // glitch, not a start bit
                    else if (at_last)  state_q <= StData;
                end
                StData: begin
                    if (decide) shift_q <= {maj, shift_q[7:1]};
                    if (at_last) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= StParity;
                    end
                end
                StParity: begin
                    if (decide)  par_bad_q <= (^shift_q) ^ maj;
                    if (at_last) state_q   <= StStop;
                end
                StStop: begin
                    if (decide) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO control: a pop frees the slot so a push while full still lands.
    always_comb begin
        pop         = i_rd_en && (count_q != '0);
        full        = (count_q == CntFW'(FIFO_DEPTH));
        do_push     = push && (!full || pop);
        overrun_evt = push && full && !pop;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !pop)      count_q <= count_q + CntFW'(1);
            else if (pop && !do_push) count_q <= count_q - CntFW'(1);
        end
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    // Sticky error flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_parity_err <= parity_evt  | (o_parity_err & ~i_clr_err);
            o_frame_err  <= frame_evt   | (o_frame_err  & ~i_clr_err);
            o_overrun    <= overrun_evt | (o_overrun    & ~i_clr_err);
        end
    end

    // FIFO status outputs.
    always_comb begin
        o_data_avail = (count_q != '0);
        o_fifo_full  = full;
        o_fifo_count = count_q;
        o_data_byte  = o_data_avail ? mem[rd_ptr_q] : 8'h00;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based frame-level model.
module tb_uart_rx_fifo;

    localparam int CPB         = 10;
    localparam int DEPTH       = 4;
    localparam int FRAME_EDGES = 11 * CPB;
    // Stop-bit decision edge counted from the first edge that sees the start bit:
    // 2 sync flops + edge detect + counter start, then mid-bit+1 of bit 10.
    localparam int PUSH_EDGE   = 10 * CPB + CPB / 2 + 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_rx, i_rd_en, i_clr_err;
    logic [7:0] o_data_byte;
    logic       o_data_avail, o_fifo_full;
    logic [2:0] o_fifo_count;
    logic       o_parity_err, o_frame_err, o_overrun;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (i_rx),
        .i_rd_en      (i_rd_en),
        .i_clr_err    (i_clr_err),
        .o_data_byte  (o_data_byte),
        .o_data_avail (o_data_avail),
        .o_fifo_full  (o_fifo_full),
        .o_fifo_count (o_fifo_count),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    bit         m_pe, m_fe, m_ov;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check_eq({tag, ".count"}, 32'(o_fifo_count), 32'(exp_q.size()));
        check_eq({tag, ".avail"}, 32'(o_data_avail), 32'(exp_q.size() > 0));
        check_eq({tag, ".full"},  32'(o_fifo_full),  32'(exp_q.size() == DEPTH));
        check_eq({tag, ".byte"},  32'(o_data_byte),  32'(head));
        check_eq({tag, ".perr"},  32'(o_parity_err), 32'(m_pe));
        check_eq({tag, ".ferr"},  32'(o_frame_err),  32'(m_fe));
        check_eq({tag, ".ovr"},   32'(o_overrun),    32'(m_ov));
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_pe = 0;
        m_fe = 0;
        m_ov = 0;
    endfunction

    // Frame-level outcome on the stop decision cycle.
    function automatic void model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                                        input bit rd, input bit clr);
        bit was_full, did_pop;
        was_full = (exp_q.size() == DEPTH);
        did_pop  = rd && (exp_q.size() > 0);
        if (clr) begin
            m_pe = 0;
            m_fe = 0;
            m_ov = 0;
        end
        if (did_pop) void'(exp_q.pop_front());
        if (bad_stop) m_fe = 1;
        else if (bad_par) m_pe = 1;
        else if (was_full && !did_pop) m_ov = 1;
        else exp_q.push_back(d);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input bit rd, input bit clr, input int rst_edge);
        logic [10:0] bits;
        bit          aborted;
        bits    = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        aborted = 0;
        for (int e = 1; e <= FRAME_EDGES && !aborted; e++) begin
            @(negedge clk);
            if (e == rst_edge) begin
                i_rx      = 1'b1;
                i_rd_en   = 1'b0;
                i_clr_err = 1'b0;
                reset     = 1'b0;
                model_reset();
                #1 check_state({tag, ".inrst"});
                idle(3);
                reset   = 1'b1;
                aborted = 1;
            end else begin
                i_rx      = bits[(e - 1) / CPB];
                i_rd_en   = rd && (e == PUSH_EDGE);
                i_clr_err = clr && (e == PUSH_EDGE);
            end
        end
        if (!aborted) begin
            model_frame(d, bad_par, bad_stop, rd, clr);
            @(negedge clk);
            i_rx      = 1'b1;
            i_rd_en   = 1'b0;
            i_clr_err = 1'b0;
            check_state(tag);
        end
        idle(4);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] head;
        @(negedge clk);
        head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check_eq({tag, ".head"}, 32'(o_data_byte), 32'(head));
        i_rd_en = 1'b1;
        @(negedge clk);
        i_rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_err(input string tag);
        @(negedge clk);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        m_pe = 0;
        m_fe = 0;
        m_ov = 0;
        check_state(tag);
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        reset     = 1'b0;
        i_rx      = 1'b1;
        i_rd_en   = 1'b0;
        i_clr_err = 1'b0;
        model_reset();
        #22 check_state("reset");
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        check_state("post_reset");

        // Good frame; byte visible right after the stop decision.
        send_frame("a5", 8'hA5, 0, 0, 0, 0, 0);
        pop_one("pop_a5");

        // Parity error, then clear.
        send_frame("par01", 8'h01, 1, 0, 0, 0, 0);
        clear_err("clr_par");

        // Short low glitch, then a frame whose start edge follows one bit-time later.
        @(negedge clk);
        i_rx = 1'b0;
        idle(3);
        i_rx = 1'b1;
        idle(CPB - 4);
        check_state("glitch");
        send_frame("after_glitch", 8'h5A, 0, 0, 0, 0, 0);
        pop_one("pop_5a");

        // Framing error, then a good frame.
        send_frame("frm3c", 8'h3C, 0, 1, 0, 0, 0);
        send_frame("good55", 8'h55, 0, 0, 0, 0, 0);
        pop_one("pop_55");
        clear_err("clr_frm");

        // Overrun on the fifth frame.
        for (int i = 0; i < 5; i++) send_frame($sformatf("fill%0d", i), 8'(8'h10 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) pop_one($sformatf("drain%0d", i));
        pop_one("pop_empty");
        clear_err("clr_ovr");

        // Push and pop on the same cycle while full.
        for (int i = 0; i < 4; i++) send_frame($sformatf("f2_%0d", i), 8'(8'h20 + i), 0, 0, 0, 0, 0);
        send_frame("push_pop_full", 8'h24, 0, 0, 1, 0, 0);
        send_frame("ovr2", 8'h25, 0, 0, 0, 0, 0);
        // Parity event with a same-cycle clear: parity stays set, overrun clears.
        send_frame("set_wins", 8'h26, 1, 0, 0, 1, 0);

        // Reset in the middle of the data bits.
        send_frame("mid_rst", 8'hC3, 0, 0, 0, 0, 3 * CPB + 2);
        check_state("after_rst");
        send_frame("post_rst_frame", 8'h96, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            r = int'($urandom_range(0, 7));
            send_frame($sformatf("rnd%0d", n), d, r == 0, r == 1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 0);
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) pop_one($sformatf("rpop%0d", n));
            if ($urandom_range(0, 4) == 0) clear_err($sformatf("rclr%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
